// File: rtl/uart_byte_packer_pkg.sv
// rtl/uart_byte_packer_pkg.sv - shared FSM states, default sync byte and sizing helper for uart_byte_packer
package uart_byte_packer_pkg;

  // Frame emission states; ST_CSUM is only reachable when UART_PACKER_CSUM_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4
  } packer_state_t;

  // Marker placed in front of every frame.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Pointer width for a buffer of the given depth; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - first-word-fall-through byte FIFO with occupancy count
module byte_fifo
  import uart_byte_packer_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  localparam int unsigned AW = ptr_width(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  // Writes into a full FIFO and reads from an empty one are ignored here,
  // so callers may request freely and watch full/empty for the outcome.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; only the slots between the pointers hold live data, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy including the full state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_byte_packer.sv
// rtl/uart_byte_packer.sv - groups UART bytes into sync/length/payload frames; optional checksum via UART_PACKER_CSUM_EN
module uart_byte_packer
  import uart_byte_packer_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN    = 64,
  parameter int unsigned BUF_DEPTH      = 128,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done_signal,
  input  logic [7:0] rx_data,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_first,
  output logic       m_last,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned CW = ptr_width(BUF_DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] PAYLOAD_C = CW'(PAYLOAD_LEN);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYCLES);

  packer_state_t state;
  packer_state_t state_nxt;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;

  logic [7:0]    frame_len;
  logic [7:0]    remaining;
  logic [TW-1:0] idle_cnt;
  logic [CW-1:0] take_len;
  logic          wr_accept;
  logic          trigger;
  logic          pop;

  assign wr_accept = rx_done_signal && !fifo_full;
  assign trigger   = (fifo_count >= PAYLOAD_C) || (!fifo_empty && (idle_cnt == TIMEOUT_C));
  assign take_len  = (fifo_count >= PAYLOAD_C) ? PAYLOAD_C : fifo_count;
  assign pop       = (state == ST_PAYLOAD) && m_ready;
  assign busy      = (state != ST_IDLE);

  byte_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_done_signal),
    .wr_data (rx_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef UART_PACKER_CSUM_EN
  logic [7:0] csum;

  // XOR of the frame's payload bytes, restarted while the sync byte is on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= 8'h00;
    end else if (state == ST_SYNC) begin
      csum <= 8'h00;
    end else if (pop) begin
      csum <= csum ^ fifo_head;
    end
  end
`endif

  // Next-state and stream outputs; every output is a decode of registered state, so
  // nothing on the stream side depends combinationally on m_ready or the rx inputs.
  always_comb begin
    state_nxt = state;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    m_first   = 1'b0;
    m_last    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          state_nxt = ST_SYNC;
        end
      end
      ST_SYNC: begin
        m_valid = 1'b1;
        m_data  = SYNC_BYTE;
        m_first = 1'b1;
        if (m_ready) begin
          state_nxt = ST_LEN;
        end
      end
      ST_LEN: begin
        m_valid = 1'b1;
        m_data  = frame_len;
        if (m_ready) begin
          state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        m_valid = 1'b1;
        m_data  = fifo_head;
        if (remaining == 8'd1) begin
`ifdef UART_PACKER_CSUM_EN
          if (m_ready) begin
            state_nxt = ST_CSUM;
          end
`else
          m_last = 1'b1;
          if (m_ready) begin
            state_nxt = ST_IDLE;
          end
`endif
        end
      end
      ST_CSUM: begin
`ifdef UART_PACKER_CSUM_EN
        m_valid = 1'b1;
        m_data  = csum;
        m_last  = 1'b1;
        if (m_ready) begin
          state_nxt = ST_IDLE;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus the frame length frozen at the trigger and the payload countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      frame_len <= 8'h00;
      remaining <= 8'h00;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && trigger) begin
        frame_len <= 8'(take_len);
        remaining <= 8'(take_len);
      end else if (pop) begin
        remaining <= remaining - 8'd1;
      end
    end
  end

  // Silence counter: restarts on each accepted byte and when a frame starts,
  // otherwise counts idle cycles with data pending and parks at the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (wr_accept) begin
      idle_cnt <= '0;
    end else if ((state == ST_IDLE) && trigger) begin
      idle_cnt <= '0;
    end else if ((state == ST_IDLE) && !fifo_empty && (idle_cnt != TIMEOUT_C)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Sticky drop flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (rx_done_signal && fifo_full) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_byte_packer.sv
// tb/tb_uart_byte_packer.sv - self-checking bench for uart_byte_packer with a queue-based frame model
module tb_uart_byte_packer;

  localparam int PL    = 64;
  localparam int DEPTH = 128;
  localparam int TO    = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done_signal = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_first;
  logic       m_last;
  logic       overflow;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  uart_byte_packer #(
    .PAYLOAD_LEN    (PL),
    .BUF_DEPTH      (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_done_signal (rx_done_signal),
    .rx_data        (rx_data),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_first        (m_first),
    .m_last         (m_last),
    .overflow       (overflow),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];       // accepted bytes not yet emitted as payload
  logic [7:0] fr[$];       // the frame currently being emitted
  int         fr_pos = 0;
  bit         mbusy = 0;
  bit         movf = 0;
  int         silence = 0;
  logic [7:0] dut_log[$];
  logic [7:0] mdl_log[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      fr.delete();
      fr_pos  = 0;
      mbusy   = 0;
      movf    = 0;
      silence = 0;
    end else begin : model_step
      bit         acc;
      int         n;
      logic [7:0] x;
      acc = rx_done_signal && (mq.size() < DEPTH);
      if (rx_done_signal && !acc) movf = 1;
      if (mbusy) begin
        if (m_ready) begin
          mdl_log.push_back(fr[fr_pos]);
          if (fr_pos >= 2 && fr_pos < 2 + int'(fr[1])) void'(mq.pop_front());
          fr_pos++;
          if (fr_pos == fr.size()) mbusy = 0;
        end
      end else if (mq.size() >= PL || (mq.size() > 0 && silence >= TO)) begin
        n = (mq.size() < PL) ? mq.size() : PL;
        fr.delete();
        fr.push_back(8'hA5);
        fr.push_back(8'(n));
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
          fr.push_back(mq[i]);
          x ^= mq[i];
        end
`ifdef UART_PACKER_CSUM_EN
        fr.push_back(x);
`endif
        fr_pos  = 0;
        mbusy   = 1;
        silence = 0;
      end else if (mq.size() > 0) begin
        silence = (silence < TO) ? silence + 1 : TO;
      end
      if (acc) begin
        mq.push_back(rx_data);
        silence = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_valid", 32'(m_valid), 32'(mbusy));
    chk("m_data", 32'(m_data), mbusy ? 32'(fr[fr_pos]) : 32'h0);
    chk("m_first", 32'(m_first), 32'(mbusy && fr_pos == 0));
    chk("m_last", 32'(m_last), 32'(mbusy && fr_pos == fr.size() - 1));
    chk("busy", 32'(busy), 32'(mbusy));
    chk("overflow", 32'(overflow), 32'(movf));
    if (!rst && m_valid && m_ready) dut_log.push_back(m_data);
  end

  // Single driver of m_ready, shortly after each active edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] sent[$];
  logic [7:0] exp[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data        = b;
    rx_done_signal = 1'b1;
    sent.push_back(b);
    tick(1);
    rx_done_signal = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((mbusy || mq.size() > 0) && n < 5000) begin
      tick(1);
      n++;
    end
    chk({name, "_drain_in_bound"}, 32'(n < 5000), 32'h1);
    tick(2);
  endtask

  task automatic add_frame(input int first, input int n);
    logic [7:0] x = 8'h00;
    exp.push_back(8'hA5);
    exp.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      exp.push_back(sent[first + i]);
      x ^= sent[first + i];
    end
`ifdef UART_PACKER_CSUM_EN
    exp.push_back(x);
`endif
  endtask

  task automatic cmp_log(input string name, input logic [7:0] got[$]);
    int bad = -1;
    chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i] && bad < 0) bad = i;
    chk({name, "_first_bad_idx"}, 32'(bad), 32'hFFFF_FFFF);
  endtask

  // Splits the observed stream into frames and compares the concatenated payload with what was sent.
  task automatic check_frames(input string name);
    logic [7:0] pay[$];
    int         pos = 0;
    int         bad_hdr = 0;
    int         len;
    logic [7:0] x;
    while (pos + 1 < dut_log.size()) begin
      if (dut_log[pos] !== 8'hA5) bad_hdr++;
      len = int'(dut_log[pos + 1]);
      if (len == 0 || len > PL) bad_hdr++;
      x = 8'h00;
      for (int i = 0; i < len && pos + 2 + i < dut_log.size(); i++) begin
        pay.push_back(dut_log[pos + 2 + i]);
        x ^= dut_log[pos + 2 + i];
      end
      pos += 2 + len;
`ifdef UART_PACKER_CSUM_EN
      if (pos < dut_log.size() && dut_log[pos] !== x) bad_hdr++;
      pos++;
`endif
    end
    if (pos != dut_log.size()) bad_hdr++;
    chk({name, "_framing"}, 32'(bad_hdr), 32'h0);
    exp = sent;
    cmp_log({name, "_payload"}, pay);
  endtask

  task automatic start_test();
    sent.delete();
    exp.delete();
    dut_log.delete();
    mdl_log.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int n;
    rst = 1'b1;
    tick(3);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_data", 32'(m_data), 32'h0);
    chk("rst_m_first", 32'(m_first), 32'h0);
    chk("rst_m_last", 32'(m_last), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(2);

    // Full frame of 00..3F with the sink always ready.
    start_test();
    for (int i = 0; i < 64; i++) send(8'(i));
    drain("full");
    add_frame(0, 64);
    cmp_log("full_dut", dut_log);
    cmp_log("full_model", mdl_log);
    if (dut_log.size() > 65) begin
      chk("full_len_byte", 32'(dut_log[1]), 32'h40);
      chk("full_last_payload", 32'(dut_log[65]), 32'h3F);
    end else begin
      chk("full_log_short", 32'(dut_log.size()), 32'd66);
    end

    // Timeout flush of three bytes; first m_valid TO+1 cycles after the last write.
    start_test();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    n = 0;
    while (!m_valid && n < 5000) begin
      tick(1);
      n++;
    end
    chk("timeout_latency", 32'(n), 32'(TO + 1));
    drain("timeout");
    add_frame(0, 3);
    cmp_log("timeout_dut", dut_log);
    cmp_log("timeout_model", mdl_log);

    // Timeout frame 01,02,04: the checksum byte, when present, is 07.
    start_test();
    send(8'h01);
    send(8'h02);
    send(8'h04);
    drain("csum_pat");
    add_frame(0, 3);
    cmp_log("csum_pat_dut", dut_log);
`ifdef UART_PACKER_CSUM_EN
    chk("csum_pat_size", 32'(dut_log.size()), 32'd6);
    if (dut_log.size() == 6) chk("csum_value", 32'(dut_log[5]), 32'h07);
`else
    chk("csum_pat_size", 32'(dut_log.size()), 32'd5);
`endif

    // Random backpressure during a 64-byte frame.
    start_test();
    ready_mode = 2;
    for (int i = 0; i < 64; i++) send(8'($urandom));
    drain("backpressure");
    check_frames("backpressure");
    ready_mode = 1;
    tick(1);

    // Overflow: sink stalled, 130 writes, the last two are dropped.
    start_test();
    ready_mode = 0;
    tick(1);
    for (int i = 0; i < 130; i++) send(8'($urandom));
    tick(2);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_stalled_sync", 32'(m_data), 32'hA5);
    ready_mode = 1;
    drain("overflow");
    add_frame(0, 64);
    add_frame(64, 64);
    cmp_log("overflow_dut", dut_log);
    chk("ovf_still_sticky", 32'(overflow), 32'h1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("ovf_cleared_by_rst", 32'(overflow), 32'h0);

    // Writes every 4 cycles while frames drain under random backpressure.
    start_test();
    ready_mode = 2;
    for (int i = 0; i < 64; i++) send(8'($urandom));
    for (int i = 0; i < 70; i++) begin
      send(8'($urandom));
      tick(3);
    end
    drain("concurrent");
    check_frames("concurrent");

    // Reset in the middle of a frame, then a clean frame afterwards.
    start_test();
    for (int i = 0; i < 64; i++) send(8'($urandom));
    tick(20);
    chk("midrst_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 32'h0);
    chk("midrst_m_data", 32'(m_data), 32'h0);
    chk("midrst_m_first", 32'(m_first), 32'h0);
    chk("midrst_m_last", 32'(m_last), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    tick(1);
    rst = 1'b0;
    ready_mode = 1;
    tick(2);
    start_test();
    send(8'h5A);
    send(8'hC3);
    send(8'h0F);
    drain("after_rst");
    add_frame(0, 3);
    cmp_log("after_rst_dut", dut_log);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
